// File: rtl/popcount_acc_pipe.sv
// popcount_acc_pipe: pipelined population-count compressor with optional
// group accumulation. An N_IN-bit vector is reduced to its ones-count through
// PIPE registered compressor stages, then a final register either emits the
// count directly or folds it into a saturating group accumulator. Both ports
// use valid/ready handshakes; one global advance signal stalls the whole pipe.
module popcount_acc_pipe #(
  parameter int N_IN  = 9,
  parameter int PIPE  = 2,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_bits,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat
);

  // Width of an exact count of N_IN bits, and number of pairwise adder levels
  // needed to fold N_IN partial counts down to one.
  localparam int CW     = $clog2(N_IN + 1);
  localparam int LEVELS = $clog2(N_IN);

  // One slot per partial count; a level of the tree pairs slots 2i and 2i+1
  // into slot i, so unused upper slots simply stay zero.
  typedef logic [N_IN-1:0][CW-1:0] vec_t;

  // Parameter sanity: a bad configuration stops elaboration.
  if (N_IN < 2) begin : g_bad_n_in
    $error("popcount_acc_pipe: N_IN must be at least 2");
  end
  if ((PIPE < 0) || (PIPE > 4)) begin : g_bad_pipe
    $error("popcount_acc_pipe: PIPE must be in 0..4");
  end
  if (ACC_W < CW) begin : g_bad_acc_w
    $error("popcount_acc_pipe: ACC_W must be at least clog2(N_IN+1)");
  end

  // Ripple adder built from full-adder cells (sum = a^b^c, carry = majority).
  // The final carry is dropped: a partial count never exceeds N_IN, which
  // always fits in CW bits.
  function automatic logic [CW-1:0] fa_add(input logic [CW-1:0] a,
                                           input logic [CW-1:0] b);
    logic [CW-1:0] s;
    logic          c;
    c = 1'b0;
    for (int k = 0; k < CW; k++) begin
      s[k] = a[k] ^ b[k] ^ c;
      c    = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
    return s;
  endfunction

  // Apply tree levels lv_from..lv_to-1 to a slot vector. An odd slot left
  // without a partner passes through unchanged (the half-adder case with a
  // zero operand collapses to a wire).
  function automatic vec_t reduce_levels(input vec_t v, input int lv_from,
                                         input int lv_to);
    vec_t cur;
    vec_t nxt;
    cur = v;
    for (int lv = 0; lv < LEVELS; lv++) begin
      if ((lv >= lv_from) && (lv < lv_to)) begin
        nxt = '0;
        for (int i = 0; i < N_IN; i++) begin
          if ((2 * i + 1) < N_IN) begin
            nxt[i] = fa_add(cur[2*i], cur[2*i+1]);
          end else if ((2 * i) < N_IN) begin
            nxt[i] = cur[2*i];
          end
        end
        cur = nxt;
      end
    end
    return cur;
  endfunction

  // Tree level at which register boundary s sits. Levels are spread evenly
  // over the PIPE compressor registers plus the final accumulation register;
  // when PIPE exceeds the level count some stages are plain delay registers.
  function automatic int level_cut(input int s);
    return (s * LEVELS) / (PIPE + 1);
  endfunction

  // Remaining levels after the last compressor register, yielding the count.
  function automatic logic [CW-1:0] final_count(input vec_t v);
    vec_t r;
    r = reduce_levels(v, level_cut(PIPE), LEVELS);
    return r[0];
  endfunction

  logic             adv;
  vec_t             in_vec;
  vec_t             tail_data;
  logic             tail_vld;
  logic             tail_acc;
  logic             tail_last;
  logic [CW-1:0]    count;
  logic [ACC_W-1:0] count_ext;
  logic [ACC_W:0]   wide_sum;
  logic             ovf;
  logic [ACC_W-1:0] sum;
  logic             sat_next;
  logic             emit;
  logic [ACC_W-1:0] acc_reg;
  logic             sat_reg;

  // Whole-pipe advance: move whenever the output slot is empty or being taken.
  always_comb begin
    adv      = !out_valid | out_ready;
    in_ready = adv & !rst;
  end

  // Spread the input bits into one-bit partial counts, one per slot.
  always_comb begin
    in_vec = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_vec[i] = CW'(in_bits[i]);
    end
  end

  if (PIPE == 0) begin : g_nopipe
    assign tail_data = in_vec;
    assign tail_vld  = in_valid & in_ready;
    assign tail_acc  = in_acc;
    assign tail_last = in_last;
  end else begin : g_pipe
    vec_t q_data [1:PIPE];
    logic q_vld  [1:PIPE];
    logic q_acc  [1:PIPE];
    logic q_last [1:PIPE];

    // Compressor stage registers: each carries its partial-count slots plus
    // the beat's valid/acc/last token; everything freezes while stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 1; s <= PIPE; s++) begin
          q_data[s] <= '0;
          q_vld[s]  <= 1'b0;
          q_acc[s]  <= 1'b0;
          q_last[s] <= 1'b0;
        end
      end else if (adv) begin
        q_data[1] <= reduce_levels(in_vec, level_cut(0), level_cut(1));
        q_vld[1]  <= in_valid & in_ready;
        q_acc[1]  <= in_acc;
        q_last[1] <= in_last;
        for (int s = 2; s <= PIPE; s++) begin
          q_data[s] <= reduce_levels(q_data[s-1], level_cut(s-1), level_cut(s));
          q_vld[s]  <= q_vld[s-1];
          q_acc[s]  <= q_acc[s-1];
          q_last[s] <= q_last[s-1];
        end
      end
    end

    assign tail_data = q_data[PIPE];
    assign tail_vld  = q_vld[PIPE];
    assign tail_acc  = q_acc[PIPE];
    assign tail_last = q_last[PIPE];
  end

  // Final count plus saturating add onto the open group's running sum. A
  // non-accumulating beat closes any open group, so it emits the group sum
  // plus its own count; with no group open acc_reg is zero.
  always_comb begin
    count     = final_count(tail_data);
    count_ext = ACC_W'(count);
    wide_sum  = {1'b0, acc_reg} + {1'b0, count_ext};
    ovf       = wide_sum[ACC_W];
    sum       = ovf ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
    sat_next  = sat_reg | ovf;
    emit      = !tail_acc | tail_last;
  end

  // Accumulation/output register: emit a result or fold into the group,
  // and drop out_valid on any advancing cycle that produces nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      sat_reg   <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      if (tail_vld && emit) begin
        out_count <= sum;
        out_sat   <= sat_next;
        out_valid <= 1'b1;
        acc_reg   <= '0;
        sat_reg   <= 1'b0;
      end else if (tail_vld) begin
        acc_reg   <= sum;
        sat_reg   <= sat_next;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_popcount_acc_pipe.sv
// Testbench for popcount_acc_pipe. Two instances (ACC_W=16 and ACC_W=4,
// both N_IN=9, PIPE=2) share one input stream. A scoreboard fed by a
// group-sum reference model checks every result; a vector table and short
// hand-written sequences pin down exact latency, saturation and reset.
module tb_popcount_acc_pipe;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [8:0]  in_bits;
  logic        in_acc;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_a;
  logic        out_valid_a;
  logic [15:0] out_count_a;
  logic        out_sat_a;

  logic        in_ready_b;
  logic        out_valid_b;
  logic [3:0]  out_count_b;
  logic        out_sat_b;

  int checks;
  int errors;
  int rx_a;

  int exp_cnt_a [$];
  int exp_sat_a [$];
  int exp_cnt_b [$];
  int exp_sat_b [$];
  int grp_sum;

  typedef struct {
    logic [8:0] bits;
    logic       acc;
    logic       last;
    logic       exp_valid;
    int         exp_count;
  } vec_row_t;

  vec_row_t tbl [10];

  popcount_acc_pipe #(.N_IN(9), .PIPE(2), .ACC_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_bits(in_bits),
    .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_count(out_count_a), .out_sat(out_sat_a)
  );

  popcount_acc_pipe #(.N_IN(9), .PIPE(2), .ACC_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_bits(in_bits),
    .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_count(out_count_b), .out_sat(out_sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] bits, input logic acc,
                               input logic last, input logic valid);
    in_bits  = bits;
    in_acc   = acc;
    in_last  = last;
    in_valid = valid;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each transferred result against the reference model,
  // then feed any accepted beat into the model. Reset empties everything.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt_a.delete();
      exp_sat_a.delete();
      exp_cnt_b.delete();
      exp_sat_b.delete();
      grp_sum = 0;
    end else begin
      checkOutput("in_ready_agree", in_ready_b, in_ready_a);
      if (out_valid_a && out_ready) begin
        rx_a++;
        if (exp_cnt_a.size() == 0) begin
          checkOutput("sb_a_unexpected", out_count_a, 32'hFFFF_FFFF);
        end else begin
          checkOutput("sb_a_count", out_count_a, exp_cnt_a.pop_front());
          checkOutput("sb_a_sat", out_sat_a, exp_sat_a.pop_front());
        end
      end
      if (out_valid_b && out_ready) begin
        if (exp_cnt_b.size() == 0) begin
          checkOutput("sb_b_unexpected", out_count_b, 32'hFFFF_FFFF);
        end else begin
          checkOutput("sb_b_count", out_count_b, exp_cnt_b.pop_front());
          checkOutput("sb_b_sat", out_sat_b, exp_sat_b.pop_front());
        end
      end
      if (in_valid && in_ready_a) begin
        int s;
        s = grp_sum + $countones(in_bits);
        if (in_acc && !in_last) begin
          grp_sum = s;
        end else begin
          exp_cnt_a.push_back((s > 65535) ? 65535 : s);
          exp_sat_a.push_back((s > 65535) ? 1 : 0);
          exp_cnt_b.push_back((s > 15) ? 15 : s);
          exp_sat_b.push_back((s > 15) ? 1 : 0);
          grp_sum = 0;
        end
      end
    end
  end

  initial begin
    int sent;
    int cyc;
    int rx_start;
    logic [8:0] cur_bits;

    checks  = 0;
    errors  = 0;
    rx_a    = 0;
    grp_sum = 0;

    tbl[0] = '{9'h1FF, 1'b0, 1'b0, 1'b1, 9};
    tbl[1] = '{9'h000, 1'b0, 1'b0, 1'b1, 0};
    tbl[2] = '{9'h155, 1'b0, 1'b0, 1'b1, 5};
    tbl[3] = '{9'h1FF, 1'b1, 1'b0, 1'b0, 0};
    tbl[4] = '{9'h1FF, 1'b1, 1'b0, 1'b0, 0};
    tbl[5] = '{9'h1FF, 1'b1, 1'b0, 1'b0, 0};
    tbl[6] = '{9'h1FF, 1'b1, 1'b1, 1'b1, 36};
    tbl[7] = '{9'h0FF, 1'b1, 1'b0, 1'b0, 0};
    tbl[8] = '{9'h003, 1'b0, 1'b0, 1'b1, 10};
    tbl[9] = '{9'h001, 1'b0, 1'b1, 1'b1, 1};

    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid_a, 0);
    checkOutput("rst_out_count", out_count_a, 0);
    checkOutput("rst_out_sat", out_sat_a, 0);
    checkOutput("rst_in_ready", in_ready_a, 0);
    nextCycle();
    rst = 1'b0;

    // Vector table: beat i presented in cycle i, its result due in cycle i+LAT
    for (int i = 0; i < 10 + LAT; i++) begin
      if (i < 10) applyStimulus(tbl[i].bits, tbl[i].acc, tbl[i].last, 1'b1);
      else        applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (i < 10) checkOutput($sformatf("tbl_in_ready_%0d", i), in_ready_a, 1);
      if (i >= LAT) begin
        checkOutput($sformatf("tbl_valid_%0d", i - LAT), out_valid_a,
                    tbl[i-LAT].exp_valid);
        if (tbl[i-LAT].exp_valid) begin
          checkOutput($sformatf("tbl_count_%0d", i - LAT), out_count_a,
                      tbl[i-LAT].exp_count);
          checkOutput($sformatf("tbl_sat_%0d", i - LAT), out_sat_a, 0);
        end
      end
      nextCycle();
    end
    repeat (2) nextCycle();

    // Saturation on the 4-bit instance: 9+9 clamps to 15, next group is clean
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       applyStimulus(9'h1FF, 1'b1, 1'b0, 1'b1);
        1:       applyStimulus(9'h1FF, 1'b1, 1'b1, 1'b1);
        2:       applyStimulus(9'h003, 1'b1, 1'b1, 1'b1);
        default: applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      if (i == 4) begin
        checkOutput("sat_b_valid", out_valid_b, 1);
        checkOutput("sat_b_count", out_count_b, 15);
        checkOutput("sat_b_flag", out_sat_b, 1);
        checkOutput("sat_a_count", out_count_a, 18);
        checkOutput("sat_a_flag", out_sat_a, 0);
      end
      if (i == 5) begin
        checkOutput("sat2_b_count", out_count_b, 2);
        checkOutput("sat2_b_flag", out_sat_b, 0);
      end
      nextCycle();
    end
    repeat (2) nextCycle();

    // Reset in the middle of a running stream
    for (int i = 0; i < 5; i++) begin
      applyStimulus(9'($urandom_range(0, 511)), 1'b0, 1'b0, 1'b1);
      nextCycle();
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid_a, 0);
    checkOutput("midrst_out_count", out_count_a, 0);
    checkOutput("midrst_out_sat", out_sat_a, 0);
    checkOutput("midrst_in_ready", in_ready_a, 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("release_in_ready", in_ready_a, 1);
    repeat (5) nextCycle();

    // Reset mid-group: the 0x0FF partial sum must not leak into the next group
    applyStimulus(9'h0FF, 1'b1, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(9'h0FF, 1'b1, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    repeat (3) nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(9'h00F, 1'b1, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    repeat (LAT - 1) nextCycle();
    @(negedge clk);
    checkOutput("grprst_valid", out_valid_a, 1);
    checkOutput("grprst_count", out_count_a, 4);
    checkOutput("grprst_count_b", out_count_b, 4);
    repeat (2) nextCycle();

    // Backpressure: 20 random per-beat counts with a 5-cycle output stall
    rx_start = rx_a;
    sent     = 0;
    cyc      = 0;
    cur_bits = 9'($urandom_range(0, 511));
    while ((sent < 20) && (cyc < 200)) begin
      out_ready = !((cyc >= 8) && (cyc < 13));
      applyStimulus(cur_bits, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      @(negedge clk);
      if (cyc == 8) begin
        checkOutput("stall_out_valid", out_valid_a, 1);
        checkOutput("stall_in_ready", in_ready_a, 0);
      end
      if (in_ready_a) begin
        sent++;
        cur_bits = 9'($urandom_range(0, 511));
      end
      nextCycle();
      cyc++;
    end
    checkOutput("bp_all_sent", sent, 20);
    out_ready = 1'b1;
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    while ((exp_cnt_a.size() != 0) && (cyc < 30)) begin
      nextCycle();
      cyc++;
    end
    repeat (2) nextCycle();
    checkOutput("bp_drained", exp_cnt_a.size(), 0);
    checkOutput("bp_received", rx_a - rx_start, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_acc_pipe.md
# popcount_acc_pipe

Pipelined, parametrised population-count compressor with an optional accumulation mode. It is the successor to the fixed 9-input, 4-output compressor. It reduces an `N_IN`-bit vector to its ones-count over `PIPE` registered compressor stages. It can either emit one count per beat or sum counts across a group of beats, as used for XNOR-popcount dot products in the NPU's binary MAC lanes. Input and output use valid/ready handshakes, with full backpressure.

## Interface
Parameters:
- `N_IN`, default 9: input vector width, ≥ 2.
- `PIPE`, default 2: registered compressor-tree stages, 0..4.
- `ACC_W`, default 16: width of the accumulator and output. Must be ≥ `CW` = clog2(`N_IN`+1); a smaller value is an elaboration error.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts the beat this cycle.
- `in_bits` in `N_IN`: vector to count.
- `in_acc` in 1: beat belongs to an accumulation group.
- `in_last` in 1: closes the accumulation group. Ignored when `in_acc`=0.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_count` out `ACC_W`: ones-count, or the group sum.
- `out_sat` out 1: the group sum saturated.

## Operation
- **Transfer rule:** a beat transfers on `in_valid`&`in_ready`. A result transfers on `out_valid`&`out_ready`.
- **Global advance:** `adv` = !`out_valid` | `out_ready`.
  - `in_ready` = `adv` & !`rst`.
  - When `adv`=0, every stage register, the accumulator and the output hold their values.
- **Stage tokens:** each compressor stage carries a valid bit plus the `in_acc` and `in_last` sidebands of its beat. Stage valid bits load from the previous stage only when `adv`=1. Bubbles propagate as valid=0.
- **Count:** count = number of 1s in `in_bits`, exact, 0..`N_IN`, `CW` bits wide. The tree is built from full/half-adder compressor cells. The cut points for `PIPE` stages are an implementation choice, but the latency below is mandatory.
- **Accumulation stage** (final register). When a valid token arrives with `adv`=1:
  - `emit` = !`acc` | `last`.
  - `sum` = `acc_reg` + zero-extended count, saturating at 2^`ACC_W`−1. `sat_next` = `sat_reg` | overflow.
  - If `emit`: `out_count`←`sum`, `out_sat`←`sat_next`, `out_valid`←1, `acc_reg`←0, `sat_reg`←0.
  - Else: `acc_reg`←`sum`, `sat_reg`←`sat_next`, and `out_valid`←0 (no output).
- **Mixed-mode group:** a non-acc beat arriving while a group is open closes that group. It emits the group's accumulated sum plus its own count.
- **Output clear:** if `adv`=1 and no token emits, `out_valid`←0. `out_count` holds its last value.
- **Reset:**
  - All stage valid bits, `acc_reg`, `sat_reg`, `out_valid`, `out_count` and `out_sat` clear to 0.
  - `in_ready` is 0 while `rst` is high.
  - Reset mid-operation discards in-flight beats and any partial group.
- **Per-beat overflow:** in non-acc mode, `out_sat` is 0 whenever `ACC_W` ≥ `CW`.

## Timing
- **Latency:** a beat accepted at edge t produces `out_valid` at edge t+`PIPE`+1, provided there is no stall and the beat emits.
  - `PIPE`=0 gives a 1-cycle registered result.
- **Throughput:** 1 beat/cycle while `out_ready`=1.
- **Stall:** `out_ready`=0 with `out_valid`=1 drops `in_ready` in the same cycle (combinational path). Nothing is lost or duplicated, and order is preserved.
- **Simultaneous events:** a result is taken and a new token emits on the same edge → the output register reloads, and `out_valid` stays 1 without a bubble.
- **Reset timing:** `rst` asserts asynchronously. Release is synchronised externally. The first beat can be accepted on the first edge with `rst`=0.
- **Accumulator saturation:** the accumulator saturates and does not wrap. The saturation flag clears with each emitted group.

## Test plan
- **Reset:** assert `rst` mid-stream with `N_IN`=9, `PIPE`=2 → `out_valid`=0, `out_count`=0, `out_sat`=0 and `in_ready`=0 during reset; `in_ready`=1 on the first edge after release.
- **Per-beat counts:** `N_IN`=9, `PIPE`=2, `in_acc`=0, back-to-back beats 0x1FF, 0x000, 0x155, `out_ready`=1, accepted at t..t+2 → `out_count` = 9, 0, 5 at edges t+3, t+4, t+5.
- **Accumulation:** `in_acc`=1, four beats 0x1FF with `in_last` on the fourth → exactly one result, `out_count`=36, `out_sat`=0, 3 cycles after the fourth beat.
- **Saturation:** `ACC_W`=4, group 0x1FF, 0x1FF(last) → 15 with `out_sat`=1. The next group, 0x003(last), gives 2 with `out_sat`=0.
- **Backpressure:** stream 20 random beats (acc=0), holding `out_ready`=0 for 5 cycles mid-stream → `in_ready` falls the same cycle, all 20 counts arrive in order and match the reference popcount, with no duplicates.
- **Reset mid-group:** two acc beats 0x0FF, then a `rst` pulse, then beat 0x00F with acc=1 and last=1 → `out_count`=4; the earlier partial sum is discarded.
